// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
// Imported by seq_alu and seq_muldiv.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_OR   = 3'b100,
        OP_NOR  = 3'b101,
        OP_NAND = 3'b110,
        OP_AND  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_multicycle(input logic [2:0] op);
        return (opcode_e'(op) == OP_MUL) || (opcode_e'(op) == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative WIDTH-cycle core: shift-add multiply (low half) and restoring
// unsigned divide. result_o/dz_o are valid in the cycle done_o is high.
module seq_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             dz_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    // x: multiplicand (MUL) or divisor (DIV); y: multiplier or dividend/quotient;
    // acc: partial product or partial remainder.
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   rem_shift;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        cnt_d     = cnt_q;
        div_d     = div_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        rem_shift = {acc_q, y_q[WIDTH-1]};

        if (start_i) begin
            cnt_d = CNT_W'(WIDTH);
            div_d = div_i;
            x_d   = div_i ? b_i : a_i;
            y_d   = div_i ? a_i : b_i;
            acc_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                // rem_shift never reaches 2*divisor, so the difference fits WIDTH bits.
                if (rem_shift >= {1'b0, x_q}) begin
                    acc_d = WIDTH'(rem_shift - {1'b0, x_q});
                    y_d   = {y_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift[WIDTH-1:0];
                    y_d   = {y_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (y_q[0]) begin
                    acc_d = acc_q + x_q;
                end
                x_d = {x_q[WIDTH-2:0], 1'b0};
                y_d = {1'b0, y_q[WIDTH-1:1]};
            end
        end
    end

    assign done_o   = (cnt_q == CNT_W'(1));
    assign dz_o     = div_q && (x_q == '0);
    assign result_o = div_q ? (dz_o ? '1 : y_d) : acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            cnt_q <= cnt_d;
        end
    end

    // NOTE: datapath registers need no reset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        div_q <= div_d;
        x_q   <= x_d;
        y_q   <= y_d;
        acc_q <= acc_d;
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle add/sub/logic,
// WIDTH-cycle MUL/DIV through seq_muldiv, registered result and flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_result;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && is_multicycle(opcode);

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .div_i    (opcode_e'(opcode) == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .done_o   (md_done),
        .result_o (md_result),
        .dz_o     (md_dz)
    );

    // Single-cycle ops; diff[WIDTH] is the unsigned borrow.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_NAND: alu_res = ~(a & b);
            OP_AND:  alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_multicycle(opcode)) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_c;
                        ovf_d    = alu_v;
                        dz_d     = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    dz_d     = md_dz;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16): expected results are queued at
// issue and compared, with latency, when out_valid rises.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         dz;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         d;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .dz        (dz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        e;
        int          sa;
        int          sb;
        int          s;
        logic [31:0] p;
        sa    = $signed(av);
        sb    = $signed(bv);
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.d   = 1'b0;
        e.lat = 1;
        case (op)
            3'b000: begin
                p     = 32'(av) + 32'(bv);
                e.res = p[W-1:0];
                e.c   = p[W];
                s     = sa + sb;
                e.v   = (s > 32767) || (s < -32768);
            end
            3'b001: begin
                e.res = av - bv;
                e.c   = (av < bv);
                s     = sa - sb;
                e.v   = (s > 32767) || (s < -32768);
            end
            3'b010: begin
                p     = 32'(av) * 32'(bv);
                e.res = p[W-1:0];
                e.lat = W + 1;
            end
            3'b011: begin
                e.lat = W + 1;
                if (bv == '0) begin
                    e.res = '1;
                    e.d   = 1'b1;
                end else begin
                    e.res = av / bv;
                end
            end
            3'b100:  e.res = av | bv;
            3'b101:  e.res = ~(av | bv);
            3'b110:  e.res = ~(av & bv);
            default: e.res = av & bv;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Issue one op, scrambling inputs after accept, then compare against the queue.
    // hold: cycles to keep out_ready low after out_valid rises.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
        exp_t e;
        int   guard;
        int   lat;
        @(negedge clk);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(guard < 50), 32'd1);
        sb_q.push_back(model(op, av, bv));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 3'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("latency", 32'(lat), 32'(e.lat));
            check("result", 32'(result), 32'(e.res));
            check("zero", 32'(zero), 32'(e.z));
            check("carry", 32'(carry), 32'(e.c));
            check("ovf", 32'(ovf), 32'(e.v));
            check("dz", 32'(dz), 32'(e.d));
            check("ready_in_done", 32'(in_ready), 32'd0);
            for (int i = 0; i < hold; i++) begin
                if (i == 1) begin
                    in_valid = 1'b1;
                    opcode   = 3'b000;
                end
                @(posedge clk);
                #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_ready", 32'(in_ready), 32'd0);
                check("hold_result", 32'(result), 32'(e.res));
                check("hold_flags", {28'd0, zero, carry, ovf, dz}, {28'd0, e.z, e.c, e.v, e.d});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("release_valid", 32'(out_valid), 32'd0);
            check("release_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        opcode    = 3'b000;
        a         = 16'h0001;
        b         = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", {11'd0, result, zero, carry, ovf, dz}, 32'd0);

        do_op(OP_ADD, 16'hFFFF, 16'h0001, 0);
        do_op(OP_SUB, 16'h8000, 16'h0001, 0);
        do_op(OP_SUB, 16'h0003, 16'h0005, 0);
        do_op(OP_ADD, 16'h7FFF, 16'h0001, 0);
        do_op(OP_MUL, 16'd300, 16'd300, 0);
        do_op(OP_DIV, 16'd1000, 16'd7, 0);
        do_op(OP_DIV, 16'd5, 16'd0, 0);
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0);
        do_op(OP_DIV, 16'hFFFF, 16'h0001, 0);
        do_op(OP_DIV, 16'd3, 16'd9, 0);
        do_op(OP_OR, 16'hF000, 16'h000F, 0);
        do_op(OP_NOR, 16'hF0F0, 16'h0F0F, 0);
        do_op(OP_NAND, 16'hFFFF, 16'hFFFF, 0);
        do_op(OP_AND, 16'hF0F0, 16'h0FF0, 0);

        do_op(OP_MUL, 16'd1234, 16'd56, 5);
        do_op(OP_ADD, 16'h1234, 16'h4321, 5);

        // Reset in cycle 8 of a DIV's BUSY phase.
        @(negedge clk);
        opcode   = OP_DIV;
        a        = 16'd1000;
        b        = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_outputs", {11'd0, result, zero, carry, ovf, dz}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        do_op(OP_AND, 16'hF0F0, 16'h0FF0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            do_op(rop, ra, rb, int'($urandom_range(0, 2)));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
